// File: rtl/dense_layer_pkg.sv
// dense_layer_pkg: shared widths and backward-pass state encoding
package dense_layer_pkg;
   localparam int DATA_W = 32;
   localparam int PROD_W = 2*DATA_W;
   typedef enum logic [1:0] {IDLE, RUN, DONE} bwd_state_t;
endpackage

// File: rtl/dense_bwd_lane.sv
// dense_bwd_lane: one element of input gradient and SGD weight update
module dense_bwd_lane import dense_layer_pkg::*; #(
   parameter int DW        = DATA_W,
   parameter int FRAC_BITS = 0,
   parameter int LR_SHIFT  = 8
) (
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] w,
   input  logic signed [DW-1:0] g,
   output logic signed [DW-1:0] grad_x,
   output logic signed [DW-1:0] w_new
);
   localparam int PW = 2*DW;
   logic signed [PW-1:0] pwg, pxg;
   assign pwg    = PW'(w) * PW'(g);
   assign pxg    = PW'(x) * PW'(g);
   assign grad_x = DW'(pwg >>> FRAC_BITS);
   assign w_new  = w - DW'(pxg >>> (FRAC_BITS + LR_SHIFT));
endmodule

// File: rtl/dense_neuron_backward.sv
// dense_neuron_backward: streams per-element input gradients and updated weights, then the updated bias
module dense_neuron_backward import dense_layer_pkg::*; #(
   parameter int N         = 64,
   parameter int DATA_W    = dense_layer_pkg::DATA_W,
   parameter int FRAC_BITS = 0,
   parameter int LR_SHIFT  = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic signed [DATA_W-1:0]  grad_out,
   input  logic signed [DATA_W-1:0]  bias,
   input  logic signed [DATA_W-1:0]  input_x [N],
   input  logic signed [DATA_W-1:0]  weights [N],
   output logic                      busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(N)-1:0]      out_idx,
   output logic signed [DATA_W-1:0]  grad_x,
   output logic signed [DATA_W-1:0]  w_new,
   output logic signed [DATA_W-1:0]  bias_new,
   output logic                      done
);
   localparam int IW = $clog2(N);
   bwd_state_t state, state_nxt;
   logic signed [DATA_W-1:0] g_r, bias_r, lane_g, lane_gx, lane_wn;
   logic [IW-1:0] lane_idx;
   logic hs, last;
   assign hs   = out_valid & out_ready;
   assign last = out_idx == IW'(N-1);
   // The lane computes the element about to be loaded: idx 0 at start (using the live g), else the successor
   assign lane_idx = (state == IDLE || last) ? '0 : out_idx + 1'b1;
   assign lane_g   = state == IDLE ? grad_out : g_r;
   dense_bwd_lane #(.DW(DATA_W), .FRAC_BITS(FRAC_BITS), .LR_SHIFT(LR_SHIFT)) u_lane (
      .x(input_x[lane_idx]),
      .w(weights[lane_idx]),
      .g(lane_g),
      .grad_x(lane_gx),
      .w_new(lane_wn)
   );
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // next state and status decode
   always_comb begin
      state_nxt = state;
      busy      = state != IDLE;
      done      = state == DONE;
      state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? ((hs && last) ? DONE : RUN) : IDLE;
   end
   // operand latches and output register stage; fields hold while stalled
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         g_r       <= '0;
         bias_r    <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         grad_x    <= '0;
         w_new     <= '0;
         bias_new  <= '0;
      end else if (state == IDLE && start) begin
         g_r       <= grad_out;
         bias_r    <= bias;
         out_valid <= 1'b1;
         out_idx   <= '0;
         grad_x    <= lane_gx;
         w_new     <= lane_wn;
      end else if (state == RUN && hs) begin
         if (last) begin
            out_valid <= 1'b0;
            bias_new  <= bias_r - (g_r >>> LR_SHIFT);
         end else begin
            out_idx <= out_idx + 1'b1;
            grad_x  <= lane_gx;
            w_new   <= lane_wn;
         end
      end
endmodule

// File: tb/tb_dense_neuron_backward.sv
// tb_dense_neuron_backward: directed vectors with a queue scoreboard and a decoupled monitor
module tb_dense_neuron_backward;
   localparam int N  = 64;
   localparam int DW = 32;
   typedef struct {logic [DW-1:0] idx; logic [DW-1:0] gx; logic [DW-1:0] wn;} elem_t;
   typedef struct {logic [DW-1:0] b; int cyc;} dexp_t;
   logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
   logic signed [DW-1:0] grad_out = 0, bias = 0;
   logic signed [DW-1:0] input_x [N];
   logic signed [DW-1:0] weights [N];
   logic busy, out_valid, done;
   logic [5:0] out_idx;
   logic signed [DW-1:0] grad_x, w_new, bias_new;
   elem_t eq[$];
   dexp_t dq[$];
   dexp_t d;
   int cyc = 0, checks = 0, passed = 0;
   logic last_done = 0;

   dense_neuron_backward #(.N(N), .DATA_W(DW), .FRAC_BITS(0), .LR_SHIFT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .grad_out(grad_out), .bias(bias),
      .input_x(input_x), .weights(weights), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .out_idx(out_idx), .grad_x(grad_x), .w_new(w_new),
      .bias_new(bias_new), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s", name);
   endtask

   // monitor: compares presented elements against the queue head, pops on handshake
   always @(negedge clk) if (rst_n) begin
      if (last_done) chk("busy_after_done", DW'(busy), 0);
      last_done <= done;
      if (busy && !done) chk("valid_in_run", DW'(out_valid), 1);
      if (out_valid) begin
         if (eq.size() == 0) fail_now("unexpected_valid");
         else begin
            chk("out_idx", DW'(out_idx), eq[0].idx);
            chk("grad_x", grad_x, eq[0].gx);
            chk("w_new", w_new, eq[0].wn);
            if (out_ready) void'(eq.pop_front());
         end
      end
      if (done) begin
         if (dq.size() == 0) fail_now("unexpected_done");
         else begin
            d = dq.pop_front();
            chk("bias_new", bias_new, d.b);
            chk("done_cycle", DW'(cyc), DW'(d.cyc));
            chk("busy_at_done", DW'(busy), 1);
            chk("valid_at_done", DW'(out_valid), 0);
         end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, DW'(busy), 0);
      chk({tag, "_valid"}, DW'(out_valid), 0);
      chk({tag, "_done"}, DW'(done), 0);
      chk({tag, "_idx"}, DW'(out_idx), 0);
      chk({tag, "_grad_x"}, grad_x, 0);
      chk({tag, "_w_new"}, w_new, 0);
      chk({tag, "_bias_new"}, bias_new, 0);
   endtask

   task automatic zero_vecs();
      for (int i = 0; i < N; i++) begin
         input_x[i] = 0;
         weights[i] = 0;
      end
   endtask

   task automatic pattern1();
      for (int i = 0; i < N; i++) begin
         input_x[i] = i;
         weights[i] = 2;
         eq.push_back('{DW'(i), 32'd8, DW'(2 - i)});
      end
   endtask

   task automatic push_zero_from(input int k);
      for (int i = k; i < N; i++) eq.push_back('{DW'(i), 32'd0, 32'd0});
   endtask

   task automatic launch(input logic [DW-1:0] g, input logic [DW-1:0] b, input logic [DW-1:0] eb, input int stall);
      @(posedge clk); #1;
      grad_out = g;
      bias = b;
      start = 1;
      dq.push_back('{eb, cyc + N + 1 + stall});
      @(posedge clk); #1;
      start = 0;
      grad_out = 12345;
      bias = 77;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) fail_now("idle_timeout");
   endtask

   task automatic wait_idx(input int k);
      int n = 0;
      while (!(out_valid && out_idx == 6'(k)) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) fail_now("idx_timeout");
   endtask

   initial begin
      zero_vecs();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1;
      // basic full-throughput pass
      pattern1();
      launch(4, 100, 99, 0);
      wait_idle();
      // stall three cycles on idx 5
      pattern1();
      launch(4, 100, 99, 3);
      wait_idx(5);
      out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1;
      wait_idle();
      // negative gradient
      zero_vecs();
      input_x[0] = 7;
      weights[0] = 5;
      eq.push_back('{32'd0, -32'sd15, 32'd11});
      push_zero_from(1);
      launch(-3, 0, 1, 0);
      wait_idle();
      // wraparound products
      zero_vecs();
      weights[0] = 32'h4000_0000;
      input_x[1] = 32'h7FFF_FFFF;
      eq.push_back('{32'd0, 32'd0, 32'h4000_0000});
      eq.push_back('{32'd1, 32'd0, 32'h8000_0001});
      push_zero_from(2);
      launch(4, 0, 32'hFFFF_FFFF, 0);
      wait_idle();
      // start ignored while running, then reset mid-pass, then clean restart
      pattern1();
      launch(4, 100, 99, 0);
      wait_idx(10);
      start = 1;
      grad_out = 50;
      bias = 5;
      @(posedge clk); #1;
      start = 0;
      wait_idx(20);
      rst_n = 0;
      #1;
      check_zero("abort");
      eq.delete();
      dq.delete();
      @(posedge clk); #1;
      rst_n = 1;
      pattern1();
      launch(4, 100, 99, 0);
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("elems_left", DW'(eq.size()), 0);
      chk("dones_left", DW'(dq.size()), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
